// File: rtl/xspi_txn_seq.sv
// ---------------------------------------------------------------------------
// xspi_txn_seq
//
// Protocol-phase sequencer that sits behind the xSPI PHY slave. It watches
// the PHY's per-transaction done strobe and captured word, walks the NOR
// flash command phases (opcode, address, dummy, data), and programs the
// PHY's next transaction (bit count, lane mode, direction, data to send).
// On the host side it exposes a command strobe, a one-word read buffer
// with valid/ready, and a write-word strobe.
//
// The system clock must run at least 8x the serial clock, so the
// synchronisers plus edge detect settle before the next sck falling edge.
//
// Optional feature macro: XSPI_SEQ_4BYTE_ADDR_EN
//   defined   : 0x13/0x0C/0x12 act as 4-byte-address READ/FAST_READ/PROGRAM
//   undefined : those opcodes are unknown and the address is always 24 bits
//
// Ports
//   clk_i, rst_ni         system clock, asynchronous active-low reset
//   phy_sce_i             chip enable from PHY (async to clk_i)
//   phy_txndone_i         PHY transaction done (sck domain)
//   phy_txndata_i         word captured by the PHY
//   phy_txnbc_o           next transaction bit count
//   phy_txnmode_o         00 single, 01 dual, 10 quad, 11 octo
//   phy_txndir_o          1 = PHY drives sio
//   phy_txndata_o         word for the PHY to shift out
//   cmd_valid_o           one-clk pulse when opcode/address are valid
//   cmd_opcode_o          last decoded opcode
//   cmd_addr_o            command address, zero-extended
//   rdata_i/rdata_valid_i host read word and its valid
//   rdata_ready_o         read buffer can take a word
//   wdata_o/wdata_valid_o received program word and its one-clk strobe
//   status_i              status byte returned for 0x05
//   underrun_o            one-clk pulse: no read word at a phase deadline
//   unknown_cmd_o         one-clk pulse: opcode not decoded
//   abort_o               one-clk pulse: CE dropped in ADDR or DUMMY
// ---------------------------------------------------------------------------
module xspi_txn_seq #(
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int DUMMY_FAST       = 8,
  parameter int DUMMY_QIO        = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        phy_sce_i,
  input  logic                        phy_txndone_i,
  input  logic [WORD_SIZE-1:0]        phy_txndata_i,
  output logic [CYCLE_COUNT_BITS-1:0] phy_txnbc_o,
  output logic [1:0]                  phy_txnmode_o,
  output logic                        phy_txndir_o,
  output logic [WORD_SIZE-1:0]        phy_txndata_o,
  output logic                        cmd_valid_o,
  output logic [7:0]                  cmd_opcode_o,
  output logic [31:0]                 cmd_addr_o,
  input  logic [WORD_SIZE-1:0]        rdata_i,
  input  logic                        rdata_valid_i,
  output logic                        rdata_ready_o,
  output logic [WORD_SIZE-1:0]        wdata_o,
  output logic                        wdata_valid_o,
  input  logic [7:0]                  status_i,
  output logic                        underrun_o,
  output logic                        unknown_cmd_o,
  output logic                        abort_o
);

  localparam logic [CYCLE_COUNT_BITS-1:0] BC_CMD    = CYCLE_COUNT_BITS'(8);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_ADDR24 = CYCLE_COUNT_BITS'(24);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_ADDR32 = CYCLE_COUNT_BITS'(32);
  localparam logic [CYCLE_COUNT_BITS-1:0] BC_WORD   = CYCLE_COUNT_BITS'(WORD_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA_RD,
    S_DATA_WR,
    S_DATA_SR,
    S_IGNORE
  } state_t;

  state_t state;

  logic sce_s1, sce_s2;
  logic done_s1, done_s2, done_s3;
  logic ce, done_evt;

  // Attributes of the opcode currently being served
  logic                        op_read;
  logic                        op_write;
  logic                        op_addr32;
  logic [1:0]                  op_mode;
  logic [CYCLE_COUNT_BITS-1:0] op_dummy;

  // One-entry read buffer between the host and phy_txndata_o
  logic                 buf_valid;
  logic [WORD_SIZE-1:0] buf_data;

  logic                        dec_known, dec_read, dec_write, dec_status, dec_addr32;
  logic [1:0]                  dec_mode;
  logic [CYCLE_COUNT_BITS-1:0] dec_dummy;

  logic        accept;
  logic        load_word;
  logic [31:0] addr_word;

  assign ce        = sce_s2;
  assign done_evt  = done_s2 & ~done_s3;
  assign addr_word = phy_txndata_i[31:0];

  // CE and done come from the sck domain; two flops each, plus a third
  // flop on done so only its rising edge counts as an event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sce_s1  <= 1'b0;
      sce_s2  <= 1'b0;
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_s3 <= 1'b0;
    end else begin
      sce_s1  <= phy_sce_i;
      sce_s2  <= sce_s1;
      done_s1 <= phy_txndone_i;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
    end
  end

  // Opcode decode of the freshly captured command byte
  always_comb begin
    dec_known  = 1'b1;
    dec_read   = 1'b0;
    dec_write  = 1'b0;
    dec_status = 1'b0;
    dec_addr32 = 1'b0;
    dec_mode   = 2'b00;
    dec_dummy  = '0;
    case (phy_txndata_i[7:0])
      8'h03: dec_read = 1'b1;
      8'h0B: begin
        dec_read  = 1'b1;
        dec_dummy = CYCLE_COUNT_BITS'(DUMMY_FAST);
      end
      8'hEB: begin
        dec_read  = 1'b1;
        dec_mode  = 2'b10;
        dec_dummy = CYCLE_COUNT_BITS'(DUMMY_QIO);
      end
      8'h02: dec_write  = 1'b1;
      8'h05: dec_status = 1'b1;
`ifdef XSPI_SEQ_4BYTE_ADDR_EN
      8'h13: begin
        dec_read   = 1'b1;
        dec_addr32 = 1'b1;
      end
      8'h0C: begin
        dec_read   = 1'b1;
        dec_addr32 = 1'b1;
        dec_dummy  = CYCLE_COUNT_BITS'(DUMMY_FAST);
      end
      8'h12: begin
        dec_write  = 1'b1;
        dec_addr32 = 1'b1;
      end
`endif
      default: dec_known = 1'b0;
    endcase
  end

  // The host may fill the buffer as soon as a read command is in its
  // address phase, so a word can be ready for the very first data phase.
  assign rdata_ready_o = ~buf_valid & ce &
                         (((state == S_ADDR) & op_read) |
                          (state == S_DUMMY) | (state == S_DATA_RD));
  assign accept = rdata_valid_i & rdata_ready_o;

  // Moments when the buffer is handed to the PHY: entry into the read data
  // phase (from ADDR or DUMMY) and every data-phase done. A CE fall in the
  // same clk takes precedence, hence the ce term.
  assign load_word = ce & done_evt &
                     (((state == S_ADDR) & op_read & (op_dummy == '0)) |
                      (state == S_DUMMY) | (state == S_DATA_RD));

  // Phase sequencer. All PHY config and host strobes are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      phy_txnbc_o   <= BC_CMD;
      phy_txnmode_o <= 2'b00;
      phy_txndir_o  <= 1'b0;
      phy_txndata_o <= '0;
      cmd_valid_o   <= 1'b0;
      cmd_opcode_o  <= 8'h00;
      cmd_addr_o    <= 32'h0;
      wdata_o       <= '0;
      wdata_valid_o <= 1'b0;
      underrun_o    <= 1'b0;
      unknown_cmd_o <= 1'b0;
      abort_o       <= 1'b0;
      buf_valid     <= 1'b0;
      buf_data      <= '0;
      op_read       <= 1'b0;
      op_write      <= 1'b0;
      op_addr32     <= 1'b0;
      op_mode       <= 2'b00;
      op_dummy      <= '0;
    end else begin
      cmd_valid_o   <= 1'b0;
      wdata_valid_o <= 1'b0;
      underrun_o    <= 1'b0;
      unknown_cmd_o <= 1'b0;
      abort_o       <= 1'b0;

      if (accept) begin
        buf_valid <= 1'b1;
        buf_data  <= rdata_i;
      end

      if (load_word) begin
        if (buf_valid) begin
          phy_txndata_o <= buf_data;
          buf_valid     <= 1'b0;
        end else begin
          phy_txndata_o <= '1;
          underrun_o    <= 1'b1;
        end
      end

      if ((state != S_IDLE) && !ce) begin
        state         <= S_IDLE;
        phy_txnbc_o   <= BC_CMD;
        phy_txnmode_o <= 2'b00;
        phy_txndir_o  <= 1'b0;
        phy_txndata_o <= '0;
        buf_valid     <= 1'b0;
        abort_o       <= (state == S_ADDR) || (state == S_DUMMY);
      end else begin
        case (state)
          S_IDLE: begin
            phy_txnbc_o   <= BC_CMD;
            phy_txnmode_o <= 2'b00;
            phy_txndir_o  <= 1'b0;
            phy_txndata_o <= '0;
            if (ce) state <= S_CMD;
          end

          S_CMD: begin
            if (done_evt) begin
              cmd_opcode_o <= phy_txndata_i[7:0];
              op_read      <= dec_read;
              op_write     <= dec_write;
              op_addr32    <= dec_addr32;
              op_mode      <= dec_mode;
              op_dummy     <= dec_dummy;
              if (!dec_known) begin
                state         <= S_IGNORE;
                unknown_cmd_o <= 1'b1;
                phy_txnbc_o   <= BC_WORD;
                phy_txnmode_o <= 2'b00;
                phy_txndir_o  <= 1'b0;
              end else if (dec_status) begin
                state         <= S_DATA_SR;
                phy_txnbc_o   <= BC_CMD;
                phy_txnmode_o <= 2'b00;
                phy_txndir_o  <= 1'b1;
                phy_txndata_o <= WORD_SIZE'(status_i);
              end else begin
                state         <= S_ADDR;
                phy_txnbc_o   <= dec_addr32 ? BC_ADDR32 : BC_ADDR24;
                phy_txnmode_o <= dec_mode;
                phy_txndir_o  <= 1'b0;
              end
            end
          end

          S_ADDR: begin
            if (done_evt) begin
              cmd_addr_o  <= op_addr32 ? addr_word : {8'h00, addr_word[23:0]};
              cmd_valid_o <= 1'b1;
              if (op_dummy != '0) begin
                // Dummy length is in sck cycles; scale to bits for the lane mode
                state        <= S_DUMMY;
                phy_txnbc_o  <= op_dummy << op_mode;
                phy_txndir_o <= 1'b0;
              end else if (op_write) begin
                state         <= S_DATA_WR;
                phy_txnbc_o   <= BC_WORD;
                phy_txnmode_o <= 2'b00;
                phy_txndir_o  <= 1'b0;
              end else begin
                state        <= S_DATA_RD;
                phy_txnbc_o  <= BC_WORD;
                phy_txndir_o <= 1'b1;
              end
            end
          end

          S_DUMMY: begin
            if (done_evt) begin
              state        <= S_DATA_RD;
              phy_txnbc_o  <= BC_WORD;
              phy_txndir_o <= 1'b1;
            end
          end

          S_DATA_WR: begin
            if (done_evt) begin
              wdata_o       <= phy_txndata_i;
              wdata_valid_o <= 1'b1;
            end
          end

          S_DATA_SR: begin
            if (done_evt) phy_txndata_o <= WORD_SIZE'(status_i);
          end

          S_DATA_RD, S_IGNORE: begin
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xspi_txn_seq.sv
// ---------------------------------------------------------------------------
// tb_xspi_txn_seq
//
// Directed bench for xspi_txn_seq. The PHY side is modelled by raising
// txndone with a captured word and holding it long enough to cross the
// synchroniser; the host side offers read words through valid/ready.
// One-clk strobes from the DUT are counted by a monitor so each scenario
// can check how many pulses it produced.
// ---------------------------------------------------------------------------
module tb_xspi_txn_seq;

  localparam int WS = 32;
  localparam int CB = 6;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          phy_sce_i;
  logic          phy_txndone_i;
  logic [WS-1:0] phy_txndata_i;
  logic [CB-1:0] phy_txnbc_o;
  logic [1:0]    phy_txnmode_o;
  logic          phy_txndir_o;
  logic [WS-1:0] phy_txndata_o;
  logic          cmd_valid_o;
  logic [7:0]    cmd_opcode_o;
  logic [31:0]   cmd_addr_o;
  logic [WS-1:0] rdata_i;
  logic          rdata_valid_i;
  logic          rdata_ready_o;
  logic [WS-1:0] wdata_o;
  logic          wdata_valid_o;
  logic [7:0]    status_i;
  logic          underrun_o;
  logic          unknown_cmd_o;
  logic          abort_o;

  int check_cnt = 0;
  int fail_cnt  = 0;

  int cmd_cnt   = 0;
  int wr_cnt    = 0;
  int und_cnt   = 0;
  int unk_cnt   = 0;
  int abort_cnt = 0;
  logic [WS-1:0] wr_log [0:7];

  xspi_txn_seq #(
    .WORD_SIZE(WS),
    .CYCLE_COUNT_BITS(CB),
    .DUMMY_FAST(8),
    .DUMMY_QIO(6)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .phy_sce_i(phy_sce_i),
    .phy_txndone_i(phy_txndone_i),
    .phy_txndata_i(phy_txndata_i),
    .phy_txnbc_o(phy_txnbc_o),
    .phy_txnmode_o(phy_txnmode_o),
    .phy_txndir_o(phy_txndir_o),
    .phy_txndata_o(phy_txndata_o),
    .cmd_valid_o(cmd_valid_o),
    .cmd_opcode_o(cmd_opcode_o),
    .cmd_addr_o(cmd_addr_o),
    .rdata_i(rdata_i),
    .rdata_valid_i(rdata_valid_i),
    .rdata_ready_o(rdata_ready_o),
    .wdata_o(wdata_o),
    .wdata_valid_o(wdata_valid_o),
    .status_i(status_i),
    .underrun_o(underrun_o),
    .unknown_cmd_o(unknown_cmd_o),
    .abort_o(abort_o)
  );

  // 100 MHz system clock
  always #5 clk_i = ~clk_i;

  // Count every one-clk strobe and log program words in arrival order
  always @(posedge clk_i) begin
    if (cmd_valid_o)   cmd_cnt   <= cmd_cnt + 1;
    if (underrun_o)    und_cnt   <= und_cnt + 1;
    if (unknown_cmd_o) unk_cnt   <= unk_cnt + 1;
    if (abort_o)       abort_cnt <= abort_cnt + 1;
    if (wdata_valid_o) begin
      if (wr_cnt < 8) wr_log[wr_cnt] <= wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Single comparison point: counts the check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkConfig(input string tag, input int bc, input int mode,
                             input int dir);
    checkOutput({tag, " txnbc"}, 64'(phy_txnbc_o), 64'(bc));
    checkOutput({tag, " mode"}, 64'(phy_txnmode_o), 64'(mode));
    checkOutput({tag, " dir"}, 64'(phy_txndir_o), 64'(dir));
  endtask

  // One PHY transaction: present the captured word and pulse txndone long
  // enough to cross the synchroniser, then let the DUT settle.
  task automatic applyStimulus(input logic [WS-1:0] word);
    phy_txndata_i = word;
    phy_txndone_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    phy_txndone_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic setCe(input logic v);
    phy_sce_i = v;
    repeat (5) @(posedge clk_i);
    #1;
  endtask

  // Host offers one read word and waits (bounded) for the handshake
  task automatic offerWord(input logic [WS-1:0] word);
    bit taken;
    taken = 1'b0;
    rdata_i       = word;
    rdata_valid_i = 1'b1;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk_i);
      if (rdata_ready_o) begin
        @(posedge clk_i);
        #1;
        taken = 1'b1;
      end
    end
    rdata_valid_i = 1'b0;
    checkOutput("rdata handshake", 64'(taken), 64'd1);
  endtask

  initial begin
    int c0, u0, w0, k0, a0;

    rst_ni        = 1'b0;
    phy_sce_i     = 1'b0;
    phy_txndone_i = 1'b0;
    phy_txndata_i = '0;
    rdata_i       = '0;
    rdata_valid_i = 1'b0;
    status_i      = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;

    // Reset state
    checkConfig("reset", 8, 0, 0);
    checkOutput("reset txndata", 64'(phy_txndata_o), 64'd0);
    checkOutput("reset ready", 64'(rdata_ready_o), 64'd0);
    checkOutput("reset cmd_addr", 64'(cmd_addr_o), 64'd0);
    checkOutput("reset opcode", 64'(cmd_opcode_o), 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // READ 0x03, word supplied during the address phase
    $display("[TB] READ with early data");
    c0 = cmd_cnt; u0 = und_cnt;
    setCe(1'b1);
    checkConfig("rd cmd", 8, 0, 0);
    applyStimulus(32'h0000_0003);
    checkConfig("rd addr", 24, 0, 0);
    offerWord(32'hDEAD_BEEF);
    applyStimulus(32'h0012_3456);
    checkConfig("rd data", 32, 0, 1);
    checkOutput("rd txndata", 64'(phy_txndata_o), 64'hDEAD_BEEF);
    checkOutput("rd cmd_addr", 64'(cmd_addr_o), 64'h0012_3456);
    checkOutput("rd opcode", 64'(cmd_opcode_o), 64'h03);
    checkOutput("rd cmd pulses", 64'(cmd_cnt - c0), 64'd1);
    checkOutput("rd no underrun", 64'(und_cnt - u0), 64'd0);
    a0 = abort_cnt;
    setCe(1'b0);
    checkConfig("rd idle", 8, 0, 0);
    checkOutput("rd no abort in data", 64'(abort_cnt - a0), 64'd0);

    // QIO READ 0xEB: quad address, 6 dummy cycles x 4 lanes, quad data
    $display("[TB] QIO READ");
    u0 = und_cnt;
    setCe(1'b1);
    applyStimulus(32'h0000_00EB);
    checkConfig("qio addr", 24, 2, 0);
    offerWord(32'h1122_3344);
    applyStimulus(32'h0000_0100);
    checkConfig("qio dummy", 24, 2, 0);
    checkOutput("qio cmd_addr", 64'(cmd_addr_o), 64'h0000_0100);
    applyStimulus(32'h0000_0000);
    checkConfig("qio data", 32, 2, 1);
    checkOutput("qio txndata", 64'(phy_txndata_o), 64'h1122_3344);
    checkOutput("qio no underrun", 64'(und_cnt - u0), 64'd0);
    setCe(1'b0);

    // PROGRAM 0x02 with two words, then a third word colliding with CE fall
    $display("[TB] PROGRAM");
    w0 = wr_cnt; c0 = cmd_cnt;
    setCe(1'b1);
    applyStimulus(32'h0000_0002);
    checkConfig("pp addr", 24, 0, 0);
    applyStimulus(32'h0000_0000);
    checkConfig("pp data", 32, 0, 0);
    checkOutput("pp cmd pulses", 64'(cmd_cnt - c0), 64'd1);
    checkOutput("pp cmd_addr", 64'(cmd_addr_o), 64'd0);
    applyStimulus(32'hA5A5_A5A5);
    applyStimulus(32'h0102_0304);
    checkOutput("pp word count", 64'(wr_cnt - w0), 64'd2);
    checkOutput("pp word 0", 64'(wr_log[w0]), 64'hA5A5_A5A5);
    checkOutput("pp word 1", 64'(wr_log[w0 + 1]), 64'h0102_0304);
    // Done and CE fall cross the synchroniser together: CE fall must win
    phy_txndata_i = 32'hFFFF_0000;
    phy_txndone_i = 1'b1;
    phy_sce_i     = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    phy_txndone_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("pp collide no word", 64'(wr_cnt - w0), 64'd2);
    checkConfig("pp collide idle", 8, 0, 0);

    // READ with no host data: underrun at phase entry and every data done
    $display("[TB] READ underrun");
    u0 = und_cnt;
    setCe(1'b1);
    applyStimulus(32'h0000_0003);
    applyStimulus(32'h0000_0010);
    checkOutput("und entry", 64'(und_cnt - u0), 64'd1);
    checkOutput("und txndata", 64'(phy_txndata_o), 64'hFFFF_FFFF);
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0000_0000);
    checkOutput("und per word", 64'(und_cnt - u0), 64'd3);
    setCe(1'b0);

    // FAST_READ aborted in the address phase, then RDSR
    $display("[TB] FAST_READ abort then RDSR");
    a0 = abort_cnt;
    setCe(1'b1);
    applyStimulus(32'h0000_000B);
    checkConfig("fr addr", 24, 0, 0);
    setCe(1'b0);
    checkOutput("fr abort", 64'(abort_cnt - a0), 64'd1);
    checkConfig("fr idle", 8, 0, 0);
    status_i = 8'h5A;
    setCe(1'b1);
    applyStimulus(32'h0000_0005);
    checkConfig("rdsr", 8, 0, 1);
    checkOutput("rdsr data", 64'(phy_txndata_o), 64'h5A);
    status_i = 8'hA5;
    applyStimulus(32'h0000_0000);
    checkOutput("rdsr repeat", 64'(phy_txndata_o), 64'hA5);
    setCe(1'b0);

    // Undecoded opcode goes to IGNORE
    $display("[TB] unknown opcode");
    k0 = unk_cnt; c0 = cmd_cnt;
    setCe(1'b1);
    applyStimulus(32'h0000_009F);
    checkOutput("unk pulse", 64'(unk_cnt - k0), 64'd1);
    checkConfig("unk ignore", 32, 0, 0);
    applyStimulus(32'h1234_5678);
    checkOutput("unk no cmd", 64'(cmd_cnt - c0), 64'd0);
    setCe(1'b0);

    // 4-byte READ opcode
    $display("[TB] READ4 0x13");
    k0 = unk_cnt; c0 = cmd_cnt;
    setCe(1'b1);
    applyStimulus(32'h0000_0013);
`ifdef XSPI_SEQ_4BYTE_ADDR_EN
    checkConfig("rd4 addr", 32, 0, 0);
    applyStimulus(32'h89AB_CDEF);
    checkOutput("rd4 cmd_addr", 64'(cmd_addr_o), 64'h89AB_CDEF);
    checkOutput("rd4 cmd pulse", 64'(cmd_cnt - c0), 64'd1);
    checkOutput("rd4 no unknown", 64'(unk_cnt - k0), 64'd0);
`else
    checkOutput("rd4 unknown", 64'(unk_cnt - k0), 64'd1);
    applyStimulus(32'h89AB_CDEF);
    checkOutput("rd4 no cmd", 64'(cmd_cnt - c0), 64'd0);
`endif
    setCe(1'b0);

    // Asynchronous reset in the middle of a command
    $display("[TB] reset mid-command");
    setCe(1'b1);
    applyStimulus(32'h0000_0003);
    phy_sce_i = 1'b0;
    rst_ni    = 1'b0;
    #2;
    checkConfig("mid reset", 8, 0, 0);
    checkOutput("mid reset opcode", 64'(cmd_opcode_o), 64'd0);
    checkOutput("mid reset addr", 64'(cmd_addr_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/xspi_txn_seq.md
Name: xspi_txn_seq

Overview:
- Protocol-phase sequencer directly downstream of the xSPI PHY slave. It consumes the PHY's txndone/txndata outputs and drives its next-transaction config (bit count, mode, direction, output data).
- Runs in the system clock domain. It walks NOR-flash command phases (opcode, address, dummy, data) and bridges them to a simple host-side command/read/write interface.
- Requirement: f_clk_i ≥ 8 × f_sck.

Parameters:
- WORD_SIZE, 32, PHY data word width; must match the PHY.
- CYCLE_COUNT_BITS, 6, width of phy_txnbc_o.
- DUMMY_FAST, 8, dummy sck cycles for 0x0B.
- DUMMY_QIO, 6, dummy sck cycles for 0xEB.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- phy_sce_i  in  1  chip enable from PHY, active high, asynchronous to clk_i
- phy_txndone_i  in  1  PHY txndone_o, sck domain
- phy_txndata_i  in  WORD_SIZE  PHY txndata_o
- phy_txnbc_o  out  CYCLE_COUNT_BITS  next transaction bit count
- phy_txnmode_o  out  2  00 single, 01 dual, 10 quad, 11 octo
- phy_txndir_o  out  1  1 = PHY drives sio
- phy_txndata_o  out  WORD_SIZE  data for PHY to shift out
- cmd_valid_o  out  1  one-clk pulse: opcode/addr valid
- cmd_opcode_o  out  8  decoded opcode
- cmd_addr_o  out  32  address, zero-extended
- rdata_i  in  WORD_SIZE  host read word
- rdata_valid_i  in  1  rdata_i valid
- rdata_ready_o  out  1  sequencer accepts rdata_i
- wdata_o  out  WORD_SIZE  received program word
- wdata_valid_o  out  1  one-clk pulse
- status_i  in  8  status register for 0x05
- underrun_o  out  1  one-clk pulse: read word missing at phase deadline
- unknown_cmd_o  out  1  one-clk pulse: undecoded opcode
- abort_o  out  1  one-clk pulse: CE dropped mid-command

Behaviour:
- Synchronisation:
  - phy_sce_i and phy_txndone_i each pass through a 2-flop synchroniser.
  - Done event = rising edge of synced txndone.
  - phy_txndata_i is captured in the done-event clk.
  - All phy_* outputs are registered and update in the done-event clk, i.e. within 3 clk of the phy_txndone_i rise, before the next sck falling edge.
- Reset values: state IDLE; phy_txnbc_o=8, phy_txnmode_o=00, phy_txndir_o=0, phy_txndata_o=0. All pulses and valids 0. rdata_ready_o=0. cmd_opcode_o/cmd_addr_o=0. Read buffer empty.
- IDLE (CE low): config held at the CMD preset (8 bits, mode 00, input). When synced CE goes high → CMD.
- CMD: on done, decode txndata[7:0]:
  - 0x03 READ: 24-bit address, mode 00, 0 dummy, read.
  - 0x0B FAST_READ: 24-bit address, mode 00, DUMMY_FAST dummy, read.
  - 0xEB QIO_READ: 24-bit address, mode 10, DUMMY_QIO dummy, read in mode 10.
  - 0x02 PROGRAM: 24-bit address, mode 00, write.
  - 0x05 RDSR: no address; data phase of 8 bits, dir 1, data=status_i, repeating.
  - Other opcodes: → IGNORE and pulse unknown_cmd_o. IGNORE sets WORD_SIZE bits, mode 00, input, and discards every word.
- ADDR: txnbc=24 (32 for 4-byte opcodes), input, mode per opcode.
  - On done: cmd_addr_o ← captured bits.
  - cmd_valid_o pulses for reads and program.
  - Next state: DUMMY if the dummy count > 0, else DATA.
- DUMMY: txnbc = cycles << mode, input. Data is discarded.
- DATA read: txnbc=WORD_SIZE, dir 1, mode per opcode. phy_txndata_o comes from a 1-entry buffer.
  - rdata_ready_o = buffer empty and state in {ADDR-complete, DUMMY, DATA}. A word is accepted when rdata_valid_i & rdata_ready_o.
  - At each phase entry and at each data done, the buffer word is loaded to phy_txndata_o and the buffer empties.
  - If the buffer is empty at that moment: load all-ones and pulse underrun_o.
  - The phase repeats until CE falls.
- DATA write: txnbc=WORD_SIZE, input, mode 00. Each done: wdata_o ← word, pulse wdata_valid_o. No backpressure.
- CE fall (synced) in any state ≠ IDLE: → IDLE within 1 clk.
  - abort_o pulses if the state is ADDR or DUMMY.
  - The buffer is flushed and a partial write word is discarded.
  - Config returns to the CMD preset.
- Simultaneous CE fall and done event: CE fall wins. No wdata/cmd pulse is emitted.
- rst_ni low mid-operation: all state returns to reset values immediately.

Optional Feature:
- Macro: XSPI_SEQ_4BYTE_ADDR_EN.
- Defined: opcodes 0x13 (READ4), 0x0C (FAST_READ4) and 0x12 (PROGRAM4) behave like 0x03/0x0B/0x02, but the ADDR phase is 32 bits and cmd_addr_o holds all 32 bits.
- Undefined: these opcodes are unknown → IGNORE with an unknown_cmd_o pulse. Address is always 24 bits, with cmd_addr_o[31:24]=0.

Test Plan:
- CE high, opcode 0x03, addr 0x123456, rdata 0xDEADBEEF ready early → cmd_valid_o pulse with addr 0x00123456; PHY config goes 8/00/0 → 24/00/0 → 32/00/1 with phy_txndata_o=0xDEADBEEF; no underrun_o.
- Opcode 0xEB, addr 0x000100 → ADDR 24/10/0, DUMMY txnbc=24 mode 10, DATA 32/10/1.
- Opcode 0x02, addr 0, words 0xA5A5A5A5 then 0x01020304 → two wdata_valid_o pulses carrying those values in order.
- Opcode 0x03 with rdata_valid_i held low → underrun_o pulses once per data word; phy_txndata_o=0xFFFFFFFF.
- Opcode 0x0B, CE dropped after 10 address bits → abort_o pulse, state IDLE, config back to 8/00/0; the next CE high accepts 0x05 and drives status_i=0x5A.
- Opcode 0x13 with the macro defined → 32-bit address 0x89ABCDEF on cmd_addr_o; without the macro → unknown_cmd_o pulse and no cmd_valid_o.
